pipe_mem_stage: RTL

PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

---
 rtl/pipe_pkg.sv | 11 +
 rtl/mem_watchdog.sv | 37 +++
 rtl/pipe_mem_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the MEM pipeline stage.
package pipe_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter for an outstanding data-memory access.
// Latency: expired is combinational from the count; clear wins over count.
module mem_watchdog
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT,
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/pipe_mem_stage.sv
// EXE/MEM register plus data-memory access FSM; non-memory ops pass in 1 cycle, memory ops stall until ack or timeout.
// Optional MEM_ALIGN_CHECK_EN: misaligned memory ops retire as a faulting bubble without touching memory.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        EXE_wreg,
  input  logic        EXE_m2reg,
  input  logic        EXE_wmem,
  input  logic [31:0] EXE_alu,
  input  logic [31:0] EXE_b,
  input  logic [4:0]  EXE_write_reg_number,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_wreg,
  output logic        MEM_m2reg,
  output logic [31:0] MEM_mem_out,
  output logic [31:0] MEM_alu,
  output logic [4:0]  MEM_write_reg_number,
  output logic        mem_fault
);

  logic        wreg_q, wreg_d;
  logic        m2reg_q, m2reg_d;
  logic        wmem_q, wmem_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rn_q, rn_d;
  mem_state_e  state_q, state_d;

  logic expired;
  logic held_mem_op;
  logic held_misaligned;
  logic ld_mem_op;
  logic ld_misaligned;

  assign held_mem_op = m2reg_q | wmem_q;
  assign ld_mem_op   = EXE_m2reg | EXE_wmem;

`ifdef MEM_ALIGN_CHECK_EN
  assign held_misaligned = (alu_q[1:0] != 2'b00);
  assign ld_misaligned   = (EXE_alu[1:0] != 2'b00);
`else
  assign held_misaligned = 1'b0;
  assign ld_misaligned   = 1'b0;
`endif

  always_comb begin
    mem_stall            = 1'b0;
    dmem_req             = 1'b0;
    dmem_we              = 1'b0;
    dmem_addr            = alu_q;
    dmem_wdata           = b_q;
    MEM_wreg             = wreg_q;
    MEM_m2reg            = m2reg_q;
    MEM_mem_out          = 32'd0;
    MEM_alu              = alu_q;
    MEM_write_reg_number = rn_q;
    mem_fault            = 1'b0;
    case (state_q)
      ACCESS: begin
        dmem_req = 1'b1;
        dmem_we  = wmem_q;
        // ack takes priority over a coinciding timeout
        if (dmem_ack) begin
          MEM_mem_out = m2reg_q ? dmem_rdata : 32'd0;
        end else begin
          MEM_wreg  = 1'b0;
          MEM_m2reg = 1'b0;
          if (expired) begin
            mem_fault = 1'b1;
          end else begin
            mem_stall = 1'b1;
          end
        end
      end
      default: begin
        // only a misaligned memory op can be held while idle
        if (held_mem_op) begin
          MEM_wreg  = 1'b0;
          MEM_m2reg = 1'b0;
          mem_fault = held_misaligned;
        end
      end
    endcase
  end

  always_comb begin
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    wmem_d  = wmem_q;
    alu_d   = alu_q;
    b_d     = b_q;
    rn_d    = rn_q;
    state_d = state_q;
    if (!mem_stall) begin
      wreg_d  = EXE_wreg;
      m2reg_d = EXE_m2reg;
      wmem_d  = EXE_wmem;
      alu_d   = EXE_alu;
      b_d     = EXE_b;
      rn_d    = EXE_write_reg_number;
      state_d = (ld_mem_op && !ld_misaligned) ? ACCESS : IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      wmem_q  <= 1'b0;
      alu_q   <= 32'd0;
      b_q     <= 32'd0;
      rn_q    <= 5'd0;
      state_q <= IDLE;
    end else begin
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      wmem_q  <= wmem_d;
      alu_q   <= alu_d;
      b_q     <= b_d;
      rn_q    <= rn_d;
      state_q <= state_d;
    end
  end

  // every load edge starts a fresh wait count; stalled ACCESS cycles advance it
  mem_watchdog #(
    .TIMEOUT (DMEM_TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (!mem_stall),
    .count   (mem_stall),
    .expired (expired)
  );

endmodule
